ldpc_dvb_dec_ctrl: RTL and testbench
====================================

# ldpc_dvb_dec_ctrl

Main controller of the LDPC DVB-S2 decoder, the receive-side counterpart of the encoder controller. It waits for a full input LLR buffer and a free output buffer, then sequences layered-free flooding iterations. Each iteration is one variable-node pass over all cycles and one check-node pass over all rows. It stops on the iteration limit or on a zero syndrome, then hands the frame to the output buffer.

## Interface
Parameters:
- pCYCLE_W, 8: width of cycle counter and cycle index.
- pROW_W, 9: width of row counter and row index.
- pITER_W, 6: width of iteration counter.
- pUSE_EARLY_TERM, 1: 1 enables stop on zero syndrome.

Ports:
- iclk  in  1  clock
- ireset  in  1  asynchronous active-high reset
- iclkena  in  1  clock enable; all state, counters and outputs advance only when high
- ibuf_full  in  1  input LLR buffer holds a frame
- obuf_empty  out  1  1-tick pulse, input buffer may be released
- iobuf_empty  in  1  output buffer free
- iused_row  in  pROW_W  check rows per pass, ≥2
- icycle_max_num  in  pCYCLE_W  vnode cycles per pass, ≥2
- iNiter  in  pITER_W  max iterations, ≥1
- ostart  out  1  1-tick frame start pulse
- ivnode_busy  in  1  vnode pipeline still flushing
- icnode_busy  in  1  cnode pipeline still flushing
- isyndrome_ok  in  1  all parity checks satisfied; sampled only in WAIT_CNODE when icnode_busy low
- ovnode_read  out  1  vnode pass read strobe
- ocycle_idx  out  pCYCLE_W  vnode cycle index
- ocnode_read  out  1  cnode pass read strobe
- orow_idx  out  pROW_W  cnode row index
- osof, oeof  out  1  first / last tick of current pass (either pass)
- oiter_idx  out  pITER_W  current iteration, 0-based
- olast_iter  out  1  oiter_idx == iNiter-1
- odone  out  1  1-tick frame done pulse
- odecfail  out  1  valid with odone; 1 = syndrome not zero
- oiter_used  out  pITER_W  valid with odone; iterations executed

## Operation
- States: RESET→WAIT; WAIT→INIT when ibuf_full & iobuf_empty; INIT→VNODE.
- VNODE→WAIT_VNODE on cycle_cnt.done; WAIT_VNODE→CNODE when !ivnode_busy.
- CNODE→WAIT_CNODE on row_cnt.done.
- WAIT_CNODE, when !icnode_busy: →DONE if olast_iter or (pUSE_EARLY_TERM & isyndrome_ok); else →VNODE with iter+1.
- DONE→WAIT.
- INIT latches iNiter, iused_row-2, icycle_max_num-2 and clears all counters; iter_cnt is cleared only here.
- Counters clear on entry to their pass.
- VNODE: cycle value +1 per tick, done <= (value == max-2). Pass length is exactly icycle_max_num ticks.
- CNODE: row value +1 per tick, same rule. Pass length is exactly iused_row ticks.
- osof = counter value 0 in the active pass; oeof = done flag.
- Strobes, indexes, osof and oeof decode combinationally from registers only.
- obuf_empty pulses the tick after the last VNODE tick of iteration 0, when channel LLRs are latched. It fires only once per frame.
- Entering DONE registers odecfail = !isyndrome_ok (forced 1 if pUSE_EARLY_TERM=0 and syndrome not ok) and oiter_used = iter+1. odone is high for the DONE tick.
- Inputs ibuf_full and iobuf_empty are ignored outside WAIT. Parameter inputs may change after INIT.

## Timing
- Reset: state RESET; all counters 0; ostart, obuf_empty, odone, odecfail, ovnode_read, ocnode_read, osof, oeof all 0; oiter_used 0.
- Reset mid-frame aborts immediately with no odone.
- ostart is registered from INIT and is high on the first VNODE tick.
- WAIT_* lasts ≥1 tick. If busy is already low, there is 1 idle tick between passes.
- Minimum frame length: 1 (INIT) + N·(C+1+R+1) + 1 (DONE), where C = icycle_max_num and R = iused_row.
- Wrap: counters never exceed max-1. The done flag forces exit before wrap.
- iclkena low freezes everything, including pulses, which stretch.

## Test plan
- C=4, R=3, iNiter=2, syndrome never ok, busy low → ocycle_idx 0..3 with osof on 0 and oeof on 3. Rows 0..2. Two iterations. odone, odecfail=1, oiter_used=2. Total 20 ticks INIT..DONE.
- Same setup, isyndrome_ok=1 in iteration 0 → stop after 1 iteration, odecfail=0, oiter_used=1, obuf_empty exactly one pulse.
- ibuf_full=1, iobuf_empty=0 for 10 ticks → stays in WAIT with no ostart. Raise iobuf_empty → ostart 2 ticks later.
- ivnode_busy held 5 ticks after VNODE → ocnode_read starts exactly 1 tick after busy falls. Same check for icnode_busy.
- iclkena toggled 50% over a full frame → output sequence identical to the iclkena=1 run, only stretched.
- ireset asserted in CNODE of iteration 1 → all outputs 0 next edge, no odone. After release, the next frame starts clean with oiter_idx=0.

Source files
------------

// File: rtl/ldpc_dvb_dec_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ldpc_dvb_dec_ctrl
// Brief    : LDPC DVB-S2 decoder main controller; sequences vnode/cnode passes
//            per iteration with iteration-limit and zero-syndrome termination.
// Revision : 1.0 - initial release
// ============================================================================
module ldpc_dvb_dec_ctrl #(
    parameter int pCYCLE_W        = 8,
    parameter int pROW_W          = 9,
    parameter int pITER_W         = 6,
    parameter int pUSE_EARLY_TERM = 1
) (
    input  logic                iclk,
    input  logic                ireset,
    input  logic                iclkena,
    input  logic                ibuf_full,
    output logic                obuf_empty,
    input  logic                iobuf_empty,
    input  logic [pROW_W-1:0]   iused_row,
    input  logic [pCYCLE_W-1:0] icycle_max_num,
    input  logic [pITER_W-1:0]  iNiter,
    output logic                ostart,
    input  logic                ivnode_busy,
    input  logic                icnode_busy,
    input  logic                isyndrome_ok,
    output logic                ovnode_read,
    output logic [pCYCLE_W-1:0] ocycle_idx,
    output logic                ocnode_read,
    output logic [pROW_W-1:0]   orow_idx,
    output logic                osof,
    output logic                oeof,
    output logic [pITER_W-1:0]  oiter_idx,
    output logic                olast_iter,
    output logic                odone,
    output logic                odecfail,
    output logic [pITER_W-1:0]  oiter_used
);

    localparam bit                 c_EARLY    = (pUSE_EARLY_TERM != 0);
    localparam logic [pCYCLE_W-1:0] c_CYC_ONE = {{(pCYCLE_W-1){1'b0}}, 1'b1};
    localparam logic [pCYCLE_W-1:0] c_CYC_TWO = {{(pCYCLE_W-2){1'b0}}, 2'b10};
    localparam logic [pROW_W-1:0]   c_ROW_ONE = {{(pROW_W-1){1'b0}}, 1'b1};
    localparam logic [pROW_W-1:0]   c_ROW_TWO = {{(pROW_W-2){1'b0}}, 2'b10};
    localparam logic [pITER_W-1:0]  c_ITER_ONE = {{(pITER_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_RESET      = 3'd0,
        ST_WAIT       = 3'd1,
        ST_INIT       = 3'd2,
        ST_VNODE      = 3'd3,
        ST_WAIT_VNODE = 3'd4,
        ST_CNODE      = 3'd5,
        ST_WAIT_CNODE = 3'd6,
        ST_DONE       = 3'd7
    } state_t;

    state_t              r_state;
    logic [pCYCLE_W-1:0] r_cyc;
    logic                r_cyc_done;
    logic [pCYCLE_W-1:0] r_cyc_max;
    logic [pROW_W-1:0]   r_row;
    logic                r_row_done;
    logic [pROW_W-1:0]   r_row_max;
    logic [pITER_W-1:0]  r_iter;
    logic [pITER_W-1:0]  r_niter;
    logic                w_last_iter;

    assign w_last_iter = (r_iter == (r_niter - c_ITER_ONE));

    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            r_state    <= ST_RESET;
            r_cyc      <= '0;
            r_cyc_done <= 1'b0;
            r_cyc_max  <= '0;
            r_row      <= '0;
            r_row_done <= 1'b0;
            r_row_max  <= '0;
            r_iter     <= '0;
            r_niter    <= '0;
            ostart     <= 1'b0;
            obuf_empty <= 1'b0;
            odone      <= 1'b0;
            odecfail   <= 1'b0;
            oiter_used <= '0;
        end else if (iclkena) begin
            ostart     <= 1'b0;
            obuf_empty <= 1'b0;
            odone      <= 1'b0;
            case (r_state)
                ST_RESET: r_state <= ST_WAIT;
                ST_WAIT: begin
                    if (ibuf_full && iobuf_empty) begin
                        r_state    <= ST_INIT;
                        r_niter    <= iNiter;
                        r_row_max  <= iused_row - c_ROW_TWO;
                        r_cyc_max  <= icycle_max_num - c_CYC_TWO;
                        r_iter     <= '0;
                        r_cyc      <= '0;
                        r_cyc_done <= 1'b0;
                        r_row      <= '0;
                        r_row_done <= 1'b0;
                    end
                end
                ST_INIT: begin
                    r_state    <= ST_VNODE;
                    ostart     <= 1'b1;
                    r_cyc      <= '0;
                    r_cyc_done <= 1'b0;
                end
                ST_VNODE: begin
                    if (r_cyc_done) begin
                        r_state    <= ST_WAIT_VNODE;
                        // channel LLRs are consumed by the end of the first vnode pass
                        obuf_empty <= (r_iter == '0);
                    end else begin
                        r_cyc      <= r_cyc + c_CYC_ONE;
                        r_cyc_done <= (r_cyc == r_cyc_max);
                    end
                end
                ST_WAIT_VNODE: begin
                    if (!ivnode_busy) begin
                        r_state    <= ST_CNODE;
                        r_row      <= '0;
                        r_row_done <= 1'b0;
                    end
                end
                ST_CNODE: begin
                    if (r_row_done) begin
                        r_state <= ST_WAIT_CNODE;
                    end else begin
                        r_row      <= r_row + c_ROW_ONE;
                        r_row_done <= (r_row == r_row_max);
                    end
                end
                ST_WAIT_CNODE: begin
                    if (!icnode_busy) begin
                        if (w_last_iter || (c_EARLY && isyndrome_ok)) begin
                            r_state    <= ST_DONE;
                            odone      <= 1'b1;
                            odecfail   <= !isyndrome_ok;
                            oiter_used <= r_iter + c_ITER_ONE;
                        end else begin
                            r_state    <= ST_VNODE;
                            r_iter     <= r_iter + c_ITER_ONE;
                            r_cyc      <= '0;
                            r_cyc_done <= 1'b0;
                        end
                    end
                end
                ST_DONE: r_state <= ST_WAIT;
                default: r_state <= ST_RESET;
            endcase
        end
    end

    assign ovnode_read = (r_state == ST_VNODE);
    assign ocnode_read = (r_state == ST_CNODE);
    assign ocycle_idx  = r_cyc;
    assign orow_idx    = r_row;
    assign osof        = (ovnode_read && (r_cyc == '0)) || (ocnode_read && (r_row == '0));
    assign oeof        = (ovnode_read && r_cyc_done) || (ocnode_read && r_row_done);
    assign oiter_idx   = r_iter;
    assign olast_iter  = w_last_iter;

endmodule
`default_nettype wire

// File: tb/tb_ldpc_dvb_dec_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ldpc_dvb_dec_ctrl
// Brief    : Self-checking bench for ldpc_dvb_dec_ctrl against a per-tick
//            frame trace built from the controller's frame rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ldpc_dvb_dec_ctrl;

    localparam int c_EARLY = 1;

    logic       iclk = 1'b0;
    logic       ireset, iclkena, ibuf_full, iobuf_empty;
    logic       ivnode_busy, icnode_busy, isyndrome_ok;
    logic [8:0] iused_row;
    logic [7:0] icycle_max_num;
    logic [5:0] iNiter;
    logic       obuf_empty, ostart, ovnode_read, ocnode_read, osof, oeof;
    logic       olast_iter, odone, odecfail;
    logic [7:0] ocycle_idx;
    logic [8:0] orow_idx;
    logic [5:0] oiter_idx, oiter_used;

    ldpc_dvb_dec_ctrl #(
        .pCYCLE_W(8), .pROW_W(9), .pITER_W(6), .pUSE_EARLY_TERM(c_EARLY)
    ) dut (
        .iclk(iclk), .ireset(ireset), .iclkena(iclkena),
        .ibuf_full(ibuf_full), .obuf_empty(obuf_empty), .iobuf_empty(iobuf_empty),
        .iused_row(iused_row), .icycle_max_num(icycle_max_num), .iNiter(iNiter),
        .ostart(ostart), .ivnode_busy(ivnode_busy), .icnode_busy(icnode_busy),
        .isyndrome_ok(isyndrome_ok), .ovnode_read(ovnode_read), .ocycle_idx(ocycle_idx),
        .ocnode_read(ocnode_read), .orow_idx(orow_idx), .osof(osof), .oeof(oeof),
        .oiter_idx(oiter_idx), .olast_iter(olast_iter), .odone(odone),
        .odecfail(odecfail), .oiter_used(oiter_used)
    );

    always #5 iclk = ~iclk;

    // One entry per enabled tick: expected outputs plus inputs to drive during it
    typedef struct packed {
        logic       vr, cr, sof, eof, last, start, bempty, done, dfail;
        logic       bv, bc, syn;
        logic [7:0] cidx;
        logic [8:0] ridx;
        logic [5:0] iter, iused;
    } step_t;

    step_t q[$];
    int    total = 0;
    int    bad   = 0;
    int    cnode1_idx;
    int    g_c, g_r, g_n;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_step(input string ph, input step_t e);
        chk({ph, ":vread"}, 32'(ovnode_read), 32'(e.vr));
        chk({ph, ":cread"}, 32'(ocnode_read), 32'(e.cr));
        chk({ph, ":sof"},   32'(osof),        32'(e.sof));
        chk({ph, ":eof"},   32'(oeof),        32'(e.eof));
        chk({ph, ":iter"},  32'(oiter_idx),   32'(e.iter));
        chk({ph, ":last"},  32'(olast_iter),  32'(e.last));
        chk({ph, ":start"}, 32'(ostart),      32'(e.start));
        chk({ph, ":bufe"},  32'(obuf_empty),  32'(e.bempty));
        chk({ph, ":done"},  32'(odone),       32'(e.done));
        if (e.vr)   chk({ph, ":cidx"},  32'(ocycle_idx), 32'(e.cidx));
        if (e.cr)   chk({ph, ":ridx"},  32'(orow_idx),   32'(e.ridx));
        if (e.done) chk({ph, ":dfail"}, 32'(odecfail),   32'(e.dfail));
        if (e.done) chk({ph, ":iused"}, 32'(oiter_used), 32'(e.iused));
    endtask

    function automatic step_t blank(input int it, input int n);
        step_t s;
        s      = '0;
        s.iter = 6'(it);
        s.last = (it == n - 1);
        return s;
    endfunction

    // Frame trace: INIT, then per iteration C vnode ticks, busy wait, R cnode ticks, busy wait
    task automatic build(input int c, input int r, input int n, input int okit,
                         input int bvlo, input int bvhi, input int bclo, input int bchi);
        step_t s;
        int    bv, bc;
        bit    syn_ok;
        g_c = c; g_r = r; g_n = n;
        q.delete();
        cnode1_idx = -1;
        q.push_back(blank(0, n));
        for (int it = 0; it < n; it++) begin
            for (int j = 0; j < c; j++) begin
                s = blank(it, n);
                s.vr = 1'b1; s.cidx = 8'(j); s.sof = (j == 0); s.eof = (j == c - 1);
                s.start = (it == 0 && j == 0); s.bv = 1'($urandom);
                q.push_back(s);
            end
            bv = int'($urandom_range(bvhi, bvlo));
            for (int k = 0; k <= bv; k++) begin
                s = blank(it, n);
                s.bempty = (it == 0 && k == 0); s.bv = (k < bv);
                q.push_back(s);
            end
            if (it == 1) cnode1_idx = q.size();
            for (int j = 0; j < r; j++) begin
                s = blank(it, n);
                s.cr = 1'b1; s.ridx = 9'(j); s.sof = (j == 0); s.eof = (j == r - 1);
                s.bc = 1'($urandom);
                q.push_back(s);
            end
            bc = int'($urandom_range(bchi, bclo));
            syn_ok = (it == okit);
            for (int k = 0; k <= bc; k++) begin
                s = blank(it, n);
                s.bc  = (k < bc);
                s.syn = (k < bc) ? 1'($urandom) : syn_ok;
                q.push_back(s);
            end
            if (it == n - 1 || (c_EARLY != 0 && syn_ok)) begin
                s = blank(it, n);
                s.done = 1'b1; s.dfail = !syn_ok; s.iused = 6'(it + 1);
                q.push_back(s);
                q.push_back(blank(it, n));
                break;
            end
        end
    endtask

    task automatic tick(input bit stretch, input bit frz, input step_t prev);
        bit en;
        int n = 0;
        do begin
            en = (stretch && n < 8) ? 1'($urandom_range(1, 0)) : 1'b1;
            n++;
            iclkena = en;
            @(posedge iclk); #1;
            if (!en && frz) check_step("frz", prev);
        end while (!en);
        iclkena = 1'b1;
    endtask

    task automatic run(input bit stretch, input int abort_at);
        icycle_max_num = 8'(g_c); iused_row = 9'(g_r); iNiter = 6'(g_n);
        ibuf_full = 1'b1; iobuf_empty = 1'b1;
        for (int t = 0; t < q.size(); t++) begin
            tick(stretch, t > 0, (t > 0) ? q[t-1] : q[0]);
            check_step($sformatf("t%0d", t), q[t]);
            if (t == abort_at) begin
                #2 ireset = 1'b1;
                #1;
                chk("rst:vread", 32'(ovnode_read), 0);
                chk("rst:cread", 32'(ocnode_read), 0);
                chk("rst:iter",  32'(oiter_idx),   0);
                chk("rst:sof",   32'(osof),        0);
                repeat (2) begin
                    @(posedge iclk); #1;
                    chk("rst:done", 32'(odone), 0);
                end
                @(negedge iclk);
                ireset = 1'b0; ibuf_full = 1'b0; ivnode_busy = 1'b0; icnode_busy = 1'b0;
                @(posedge iclk); #1;
                return;
            end
            ivnode_busy  = q[t].bv;
            icnode_busy  = q[t].bc;
            isyndrome_ok = q[t].syn;
            ibuf_full    = (t == q.size() - 1) ? 1'b0 : 1'($urandom);
            iobuf_empty  = 1'($urandom);
            iNiter       = 6'($urandom);
            iused_row    = 9'($urandom);
            icycle_max_num = 8'($urandom);
        end
    endtask

    initial begin
        ireset = 1'b1; iclkena = 1'b1; ibuf_full = 1'b0; iobuf_empty = 1'b0;
        ivnode_busy = 1'b0; icnode_busy = 1'b0; isyndrome_ok = 1'b0;
        iused_row = 9'd3; icycle_max_num = 8'd4; iNiter = 6'd2;
        repeat (3) @(posedge iclk);
        #1;
        chk("reset:start", 32'(ostart),      0);
        chk("reset:bufe",  32'(obuf_empty),  0);
        chk("reset:done",  32'(odone),       0);
        chk("reset:dfail", 32'(odecfail),    0);
        chk("reset:vread", 32'(ovnode_read), 0);
        chk("reset:cread", 32'(ocnode_read), 0);
        chk("reset:sof",   32'(osof),        0);
        chk("reset:eof",   32'(oeof),        0);
        chk("reset:iused", 32'(oiter_used),  0);
        @(negedge iclk) ireset = 1'b0;
        @(posedge iclk); #1;

        ibuf_full = 1'b1; iobuf_empty = 1'b0;
        repeat (10) begin
            @(posedge iclk); #1;
            chk("hold:start", 32'(ostart),      0);
            chk("hold:vread", 32'(ovnode_read), 0);
        end

        build(4, 3, 2, -1, 0, 0, 0, 0); run(1'b0, -1);
        build(4, 3, 2,  0, 0, 0, 0, 0); run(1'b0, -1);
        build(4, 3, 2, -1, 5, 5, 5, 5); run(1'b0, -1);
        build(4, 3, 2, -1, 0, 0, 0, 0); run(1'b1, -1);
        build(4, 3, 2, -1, 0, 1, 0, 1); run(1'b0, cnode1_idx);
        build(3, 2, 3,  1, 0, 2, 0, 2); run(1'b0, -1);
        build(2, 2, 1, -1, 0, 0, 0, 0); run(1'b0, -1);

        for (int f = 0; f < 8; f++) begin
            int c, r, n, ok;
            c  = int'($urandom_range(6, 2));
            r  = int'($urandom_range(6, 2));
            n  = int'($urandom_range(4, 1));
            ok = int'($urandom_range(n, 0)) - 1;
            build(c, r, n, ok, 0, 3, 0, 3);
            run(1'($urandom), -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
